// File: rtl/sigma_delta_adc.sv
// First-order 1-bit delta-sigma ADC front end: synchronizes the comparator,
// closes the loop through fb_out and decimates by accumulate-and-dump.
module sigma_delta_adc #(
  parameter int          DECIM_LOG2 = 8,      // legal range 8..12
  parameter logic [7:0]  HYST_HI    = 8'd160,
  parameter logic [7:0]  HYST_LO    = 8'd96
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       cmp_in,
  output logic       fb_out,
  output logic [7:0] sample,
  output logic       sample_valid,
  output logic       ear_bit
);

  localparam int            N        = DECIM_LOG2;
  localparam logic [N-1:0]  WCNT_ONE = {{(N-1){1'b0}}, 1'b1};

  logic         s1;
  logic         s2;
  logic [N-1:0] wcnt;
  logic [N:0]   acc;
  logic [N:0]   total;
  logic [7:0]   next_sample;
  logic         dump;

  // Window total including the current bit; only a full window of ones
  // reaches bit N, which saturates instead of wrapping.
  always_comb begin
    total       = acc + {{N{1'b0}}, s2};
    next_sample = total[N] ? 8'hFF : total[N-1 -: 8];
    dump        = (wcnt == {N{1'b1}});
  end

  // NOTE: state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, regardless of statement order.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1           <= 1'b0;
      s2           <= 1'b0;
      fb_out       <= 1'b0;
      wcnt         <= '0;
      acc          <= '0;
      sample       <= 8'h80;
      sample_valid <= 1'b0;
      ear_bit      <= 1'b0;
    end else begin
      s1     <= cmp_in;
      s2     <= s1;
      fb_out <= s2;     // kept a bare flop so it can be packed into the IOB
      wcnt   <= wcnt + WCNT_ONE;
      if (dump) begin
        acc          <= '0;
        sample       <= next_sample;
        sample_valid <= 1'b1;
        if (next_sample >= HYST_HI)
          ear_bit <= 1'b1;
        else if (next_sample <= HYST_LO)
          ear_bit <= 1'b0;
      end else begin
        acc          <= total;
        sample_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc: N=8 and N=10 instances, constant,
// toggle, duty and RC-loopback stimulus with hand-computed expectations.
module tb_sigma_delta_adc;

  localparam int M_ZERO = 0;
  localparam int M_ONE  = 1;
  localparam int M_TOG  = 2;
  localparam int M_DUTY = 3;
  localparam int M_RC   = 4;

  logic       Clk = 1'b0;
  logic       rst8 = 1'b1, rst10 = 1'b1;
  logic       cmp8 = 1'b0, cmp10 = 1'b0;
  logic       fb8, fb10;
  logic [7:0] sample8, sample10;
  logic       valid8, valid10;
  logic       ear8, ear10;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-run strobe records (edges counted from reset release).
  int         e;
  int         n_strobe;
  int         first_edge, last_edge, min_per, max_per;
  logic [7:0] samples[$];
  logic       ears[$];
  real        vint;

  sigma_delta_adc #(.DECIM_LOG2(8)) dut8 (
    .Clk(Clk), .Reset(rst8), .cmp_in(cmp8), .fb_out(fb8),
    .sample(sample8), .sample_valid(valid8), .ear_bit(ear8)
  );

  sigma_delta_adc #(.DECIM_LOG2(10)) dut10 (
    .Clk(Clk), .Reset(rst10), .cmp_in(cmp10), .fb_out(fb10),
    .sample(sample10), .sample_valid(valid10), .ear_bit(ear10)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_records();
    e          = 0;
    n_strobe   = 0;
    first_edge = -1;
    last_edge  = 0;
    min_per    = 1 << 30;
    max_per    = 0;
    samples.delete();
    ears.delete();
    vint       = 0.0;
  endtask

  // Called at posedge+1; holds Reset across one edge and releases between edges.
  task automatic do_reset(input int which);
    if (which == 8) rst8 = 1'b1; else rst10 = 1'b1;
    @(posedge Clk); #1;
    if (which == 8) rst8 = 1'b0; else rst10 = 1'b0;
    clear_records();
  endtask

  task automatic run(input int which, input int edges, input int mode, input int ones);
    int   w;
    int   pos;
    logic v;
    logic vld;
    logic [7:0] s;
    logic ear;
    logic fb;
    w = (which == 8) ? 256 : 1024;
    for (int i = 0; i < edges; i++) begin
      pos = e % w;
      case (mode)
        M_ZERO:  v = 1'b0;
        M_ONE:   v = 1'b1;
        M_TOG:   v = (e % 2 == 0);
        M_DUTY:  v = (pos < ones);
        default: v = (vint < 0.25);
      endcase
      if (which == 8) cmp8 = v; else cmp10 = v;
      @(posedge Clk); #1;
      e++;
      vld = (which == 8) ? valid8  : valid10;
      s   = (which == 8) ? sample8 : sample10;
      ear = (which == 8) ? ear8    : ear10;
      fb  = (which == 8) ? fb8     : fb10;
      if (mode == M_RC)
        vint = vint + 0.02 * ((fb ? 1.0 : 0.0) - vint);
      if (vld) begin
        if (n_strobe == 0) first_edge = e;
        else begin
          if (e - last_edge < min_per) min_per = e - last_edge;
          if (e - last_edge > max_per) max_per = e - last_edge;
        end
        last_edge = e;
        samples.push_back(s);
        ears.push_back(ear);
        n_strobe++;
      end
    end
  endtask

  initial begin
    int rc_s;
    clear_records();
    @(posedge Clk); @(posedge Clk); #1;
    check("rst_sample", sample8, 8'h80);
    check("rst_valid", valid8, 0);
    check("rst_ear", ear8, 0);
    check("rst_fb", fb8, 0);
    rst8 = 1'b0;
    rst10 = 1'b0;
    clear_records();

    // Constant 1, N=8
    run(8, 2, M_ONE, 0);
    check("one_fb_e2", fb8, 0);
    run(8, 1, M_ONE, 0);
    check("one_fb_e3", fb8, 1);
    run(8, 253, M_ONE, 0);
    check("one_first_strobe_cnt", n_strobe, 1);
    check("one_first_edge", first_edge, 256);
    check("one_first_sample", samples[0], 254);
    check("one_first_ear", ears[0], 1);
    run(8, 512, M_ONE, 0);
    check("one_strobes", n_strobe, 3);
    check("one_sample1", samples[1], 255);
    check("one_sample2", samples[2], 255);
    check("one_min_per", min_per, 256);
    check("one_max_per", max_per, 256);
    check("one_fb_late", fb8, 1);

    // Mid-window reset at wcnt=100
    run(8, 100, M_ONE, 0);
    rst8 = 1'b1;
    #3;
    check("mid_rst_sample", sample8, 8'h80);
    check("mid_rst_valid", valid8, 0);
    check("mid_rst_ear", ear8, 0);
    check("mid_rst_fb", fb8, 0);
    #7;
    rst8 = 1'b0;
    clear_records();
    run(8, 300, M_ONE, 0);
    check("mid_rst_first_edge", first_edge, 256);
    check("mid_rst_sample0", samples[0], 254);

    // Constant 0
    do_reset(8);
    run(8, 768, M_ZERO, 0);
    check("zero_strobes", n_strobe, 3);
    check("zero_first_edge", first_edge, 256);
    check("zero_sample0", samples[0], 0);
    check("zero_sample2", samples[2], 0);
    check("zero_per", max_per, 256);
    check("zero_ear", ear8, 0);
    check("zero_fb", fb8, 0);

    // Toggle
    do_reset(8);
    run(8, 768, M_TOG, 0);
    check("tog_sample1", samples[1], 128);
    check("tog_sample2", samples[2], 128);
    check("tog_ear", ears[2], 0);

    // Hysteresis
    do_reset(8);
    run(8, 512, M_DUTY, 170);
    check("hys170_sample", samples[1], 170);
    check("hys170_ear", ears[1], 1);
    run(8, 512, M_DUTY, 128);
    check("hys128a_sample", samples[3], 128);
    check("hys128a_ear", ears[3], 1);
    run(8, 512, M_DUTY, 90);
    check("hys90_sample", samples[5], 90);
    check("hys90_ear", ears[5], 0);
    run(8, 512, M_DUTY, 128);
    check("hys128b_sample", samples[7], 128);
    check("hys128b_ear", ears[7], 0);

    // N=10
    do_reset(10);
    run(10, 1024, M_ONE, 0);
    check("n10_first_edge", first_edge, 1024);
    check("n10_one_sample", samples[0], 255);
    run(10, 2048, M_TOG, 0);
    check("n10_tog_sample", samples[2], 128);
    check("n10_min_per", min_per, 1024);
    check("n10_max_per", max_per, 1024);

    do_reset(10);
    run(10, 6144, M_RC, 0);
    rc_s = int'(samples[5]);
    check("n10_rc_strobes", n_strobe, 6);
    check("n10_rc_track", (rc_s >= 62 && rc_s <= 66) ? 64 : rc_s, 64);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sigma_delta_adc.md
# sigma_delta_adc

First-order 1-bit delta-sigma ADC front end, the capture-side counterpart of the audio sigma-delta DAC. It takes the output of an external comparator (LVDS pair or pin comparator against an RC integrator), drives the integrator feedback pin and decimates the bitstream with accumulate-and-dump. The result is an 8-bit excess-128 sample, the same format the DAC consumes. It also produces a hysteresis-filtered EAR bit for the tape-loading path.

## Interface
Parameters:
- DECIM_LOG2, 8: log2 of decimation ratio; legal range 8..12; window = 2^DECIM_LOG2 clocks.
- HYST_HI, 8'd160: sample value at or above which ear_bit sets.
- HYST_LO, 8'd96: sample value at or below which ear_bit clears; HYST_LO < HYST_HI required.

Ports:
- Clk, input, 1: single clock for all logic (the DAC clock domain).
- Reset, input, 1: asynchronous assert, active-high; all state returns to reset values while high.
- cmp_in, input, 1: comparator output, asynchronous to Clk; 1 = analog input above integrator voltage.
- fb_out, output, 1: feedback to RC integrator; registered, IOB flop.
- sample, output, 8: last decimated sample, excess-128 unsigned.
- sample_valid, output, 1: one-cycle strobe, sample updated this cycle.
- ear_bit, output, 1: hysteresis-thresholded level of sample.

## Operation
- Synchronizer: two flops s1, s2 on cmp_in. Bitstream bit b = s2 (current registered value).
- Feedback: fb_out <= s2 every edge. Loop closure is the external RC; no digital integrator.
- Window counter wcnt, DECIM_LOG2 bits, increments every edge and wraps 2^N-1 -> 0.
- Accumulator acc, DECIM_LOG2+1 bits, counts ones: acc <= acc + b every edge, except at the dump edge.
- Dump edge (wcnt == 2^N-1): total = acc + b (range 0..2^N). Then:
  - sample <= (total == 2^N) ? 8'd255 : total >> (N-8).
  - acc <= 0.
  - sample_valid <= 1.
- All other edges: sample_valid <= 0 and sample holds.
- ear_bit is updated only at the dump edge, from the new sample value s':
  - s' >= HYST_HI -> 1.
  - s' <= HYST_LO -> 0.
  - otherwise hold.
- Reset values: s1 = s2 = 0, fb_out = 0, wcnt = 0, acc = 0, sample = 8'h80, sample_valid = 0, ear_bit = 0.

## Timing
- cmp_in to b: 2 edges. cmp_in to fb_out: 3 edges.
- The first window after Reset deasserts covers edges 1..2^N; the first sample_valid is high after edge 2^N. Thereafter sample_valid pulses every 2^N edges, exactly 1 cycle wide.
- sample, sample_valid and ear_bit change on the same edge.
- Because the synchronizer resets to 0, the first window loses 2 input bits: with constant-1 input the first sample is (2^N-2) >> (N-8).
- Reset asserted mid-window: all outputs take reset values immediately, without waiting for a clock. The partial window is discarded. On release, the window restarts at wcnt = 0.
- Saturation: only total == 2^N saturates. No wrap to 0 is permitted.

## Test plan
- N=8, cmp_in held 1 from reset release:
  - First sample_valid after edge 256 with sample=254.
  - All later samples 255.
  - ear_bit=1 from the first strobe on.
  - fb_out=1 from edge 3.
- cmp_in held 0: every sample 0, ear_bit 0, fb_out 0, strobe period 256.
- cmp_in toggling 1/0 every Clk (synchronous to Clk): samples from the second window onward equal 128; ear_bit stays 0.
- Hysteresis:
  - Duty pattern giving 170 ones per window -> ear_bit 1.
  - Then 128 per window -> ear_bit stays 1.
  - Then 90 per window -> ear_bit 0.
  - Then 128 -> stays 0.
- Reset pulse at wcnt=100 (one Clk-period wide, between edges):
  - sample=8'h80, sample_valid=0, ear_bit=0 and fb_out=0 before the next edge.
  - Next strobe occurs exactly 256 edges after release.
- DECIM_LOG2=10:
  - Constant 1 -> 255 after the first window.
  - Toggle -> 128.
  - Strobe period 1024.
  - Loopback through a behavioral RC model driven by fb_out tracks a DC input of 0.25 full-scale to 64±2.
